// File: rtl/sigmoid_pipe.sv
// Streaming multi-lane sigmoid using a shift-only piecewise-linear approximation, 3-stage pipeline.
// Define SIGMOID_SATCNT_EN to add the sat_cnt port counting lanes that hit the saturated region.
module sigmoid_pipe #(
  parameter int LANES  = 1,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 3,
  parameter int OUT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data
`ifdef SIGMOID_SATCNT_EN
  ,
  output logic [15:0]               sat_cnt
`endif
);

  localparam int IF_W = FRAC_W + 5;
  localparam int YW   = IF_W + 1;
  localparam int AW   = DATA_W + 3;
  localparam int SW   = DATA_W + IF_W + 2;
  localparam int RW   = YW + OUT_W + 1;
  localparam int RSH  = (IF_W > OUT_W) ? IF_W - OUT_W : 0;
  localparam int LSH  = (OUT_W > IF_W) ? OUT_W - IF_W : 0;

  // 2.375 is rounded up when FRAC_W cannot represent it exactly
  localparam logic [AW-1:0] TH_R1   = AW'(1 << FRAC_W);
  localparam logic [AW-1:0] TH_R2   = AW'((19 * (1 << FRAC_W) + 7) / 8);
  localparam logic [AW-1:0] TH_R3   = AW'(5 * (1 << FRAC_W));
  localparam logic [RW-1:0] HALF    = RW'((1 << RSH) >> 1);
  localparam logic [RW-1:0] OUT_MAX = RW'({OUT_W{1'b1}});
  localparam logic [YW-1:0] Y_ONE   = {1'b1, {IF_W{1'b0}}};

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [1:0] region(input logic [DATA_W-1:0] a);
    logic [AW-1:0] ax;
    ax = AW'(a);
    if (ax < TH_R1)      return 2'd0;
    else if (ax < TH_R2) return 2'd1;
    else if (ax < TH_R3) return 2'd2;
    else                 return 2'd3;
  endfunction

  // Slopes are pure shifts of a into the IF_W-fraction domain, so every segment is exact
  function automatic logic [YW-1:0] plan_y(input logic [DATA_W-1:0] a, input logic [1:0] rg);
    logic [SW-1:0] ax;
    logic [SW-1:0] y;
    ax = SW'(a);
    case (rg)
      2'd0:    y = (ax << 3) + (SW'(1) << (IF_W - 1));
      2'd1:    y = (ax << 2) + (SW'(5) << (IF_W - 3));
      2'd2:    y = ax + (SW'(27) << FRAC_W);
      default: y = SW'(Y_ONE);
    endcase
    return YW'(y);
  endfunction

  function automatic logic [OUT_W-1:0] round_sat(input logic [YW-1:0] y, input logic s);
    logic [YW-1:0] t;
    logic [RW-1:0] v;
    t = s ? (Y_ONE - y) : y;
    v = ((RW'(t) + HALF) >> RSH) << LSH;
    return (v > OUT_MAX) ? {OUT_W{1'b1}} : OUT_W'(v);
  endfunction

  logic              en;
  logic              vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0] a_p0  [LANES];
  logic [1:0]        rg_p0 [LANES];
  logic [LANES-1:0]  s_p0;
  logic [YW-1:0]     y_p1  [LANES];
  logic [LANES-1:0]  s_p1;

  assign en        = ~vld_p2 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        // p0: magnitude, sign, region
        a_p0[i]  <= abs_val(in_data[i*DATA_W +: DATA_W]);
        rg_p0[i] <= region(abs_val(in_data[i*DATA_W +: DATA_W]));
        s_p0[i]  <= in_data[i*DATA_W + DATA_W - 1];
        // p1: positive-half PLAN value
        y_p1[i]  <= plan_y(a_p0[i], rg_p0[i]);
        s_p1[i]  <= s_p0[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      // p2: mirror for negative inputs, round, clamp
      for (int i = 0; i < LANES; i++)
        out_data[i*OUT_W +: OUT_W] <= round_sat(y_p1[i], s_p1[i]);
    end
  end

`ifdef SIGMOID_SATCNT_EN
  logic [LANES-1:0] r3_p1;
  logic [LANES-1:0] r3_p2;
  logic [31:0]      sat_sum;
  logic [15:0]      sat_nxt;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++)
        r3_p1[i] <= (rg_p0[i] == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r3_p2 <= '0;
    else if (en) r3_p2 <= r3_p1;
  end

  always_comb begin
    sat_sum = 32'(sat_cnt);
    for (int i = 0; i < LANES; i++)
      sat_sum = sat_sum + 32'(r3_p2[i]);
    sat_nxt = (sat_sum > 32'h0000_FFFF) ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   sat_cnt <= 16'd0;
    else if (vld_p2 && out_ready) sat_cnt <= sat_nxt;
  end
`endif

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed bench for sigmoid_pipe: single-lane and four-lane instances, reference computed in real arithmetic.
module tb_sigmoid_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] in_data4, out_data4;
`ifdef SIGMOID_SATCNT_EN
  logic [15:0] sat_cnt, sat_cnt4;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] xs [256];

  always #5 clk = ~clk;

  sigmoid_pipe #(.LANES(1), .DATA_W(8), .FRAC_W(3), .OUT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SIGMOID_SATCNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  sigmoid_pipe #(.LANES(4), .DATA_W(8), .FRAC_W(3), .OUT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
`ifdef SIGMOID_SATCNT_EN
    , .sat_cnt(sat_cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int model(input logic [7:0] x);
    int  xi;
    real a, y;
    int  v;
    xi = $signed(x);
    a  = ((xi < 0) ? -xi : xi) / 8.0;
    if (a < 1.0)        y = a / 4.0 + 0.5;
    else if (a < 2.375) y = a / 8.0 + 0.625;
    else if (a < 5.0)   y = a / 32.0 + 0.84375;
    else                y = 1.0;
    if (xi < 0) y = 1.0 - y;
    v = $rtoi(y * 256.0 + 0.5);
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic send_one(input logic [7:0] x, input int exp, input string tag);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    tick();
  endtask

  // Streams xs[0..n-1]; out_ready held low for cycles st_lo..st_hi (st_lo<0: never)
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input bit mono,
                            input string tag);
    int k = 0;
    int rcv = 0;
    logic [7:0] prev = 8'd0;
    logic [7:0] held = 8'd0;
    for (int c = 0; c < n + 40 && rcv < n; c++) begin
      out_ready = !(c >= st_lo && c <= st_hi);
      in_valid  = (k < n);
      in_data   = (k < n) ? xs[k] : 8'd0;
      #1;
      if (st_lo >= 0 && c <= st_hi + 2)
        check({tag, "_in_ready"}, 32'(in_ready), (c >= st_lo && c <= st_hi) ? 32'd0 : 32'd1);
      if (c == st_lo) held = out_data;
      if (st_lo >= 0 && c > st_lo && c <= st_hi)
        check({tag, "_stall_hold"}, 32'(out_data), 32'(held));
      if (out_valid && out_ready) begin
        check({tag, "_data"}, 32'(out_data), 32'(model(xs[rcv])));
        if (mono && rcv > 0)
          check({tag, "_monotonic"}, 32'(out_data >= prev), 32'd1);
        prev = out_data;
        rcv++;
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 32'(rcv), 32'(n));
    tick();
    tick();
    check({tag, "_no_extra"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    out_ready  = 1'b1;
    in_valid4  = 1'b0;
    in_data4   = 32'd0;
    out_ready4 = 1'b1;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data4", out_data4, 32'd0);
`ifdef SIGMOID_SATCNT_EN
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency: beat captured at first edge, visible after the third
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    check("lat_c1_vld", 32'(out_valid), 32'd0);
    tick();
    check("lat_c2_vld", 32'(out_valid), 32'd0);
    tick();
    check("lat_c3_vld", 32'(out_valid), 32'd1);
    check("lat_c3_data", 32'(out_data), 32'd128);
    tick();
    check("lat_c4_vld", 32'(out_valid), 32'd0);

    send_one(8'h08, 192, "pos1");
    send_one(8'hF8, 64, "neg1");
    send_one(8'h10, 224, "pos2");
    send_one(8'h40, 255, "pos8");
    send_one(8'h80, 0, "neg16");
    send_one(8'h13, 235, "edge2375");
    send_one(8'h27, 255, "below5");
    send_one(8'h28, 255, "at5");
    send_one(8'hFF, 120, "negeighth");

    for (int i = 0; i < 10; i++) xs[i] = 8'(i * 7 - 35);
    run_stream(10, 4, 6, 1'b0, "b2b");

    // Reset with three beats in flight
    in_valid = 1'b1;
    in_data  = 8'h08;
    tick();
    in_data  = 8'h10;
    tick();
    in_data  = 8'h40;
    tick();
    in_valid = 1'b0;
    check("mid_pre_vld", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_post_vld", 32'(out_valid), 32'd0);
    end

    // Four lanes: {+15.875, -1.0, 0, +8.0} from lane 3 down to lane 0
`ifdef SIGMOID_SATCNT_EN
    check("l4_sat_before", 32'(sat_cnt4), 32'd0);
`endif
    in_valid4 = 1'b1;
    in_data4  = {8'h7F, 8'hF8, 8'h00, 8'h40};
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    check("l4_vld", 32'(out_valid4), 32'd1);
    check("l4_data", out_data4, {8'd255, 8'd64, 8'd128, 8'd255});
    tick();
    check("l4_vld_after", 32'(out_valid4), 32'd0);
`ifdef SIGMOID_SATCNT_EN
    check("l4_sat_after", 32'(sat_cnt4), 32'd2);
`endif

    for (int i = 0; i < 256; i++) xs[i] = 8'(i - 128);
    run_stream(256, -1, -1, 1'b1, "exh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
